snake_head_stepper: RTL

SNAKE_HEAD_STEPPER -- requirements
Module: snake_head_stepper

---
 rtl/snake_head_stepper.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/snake_head_stepper.sv
// Snake head stepper: moves a head cell one position per accepted STEP on a
// wrap-around grid. Every step runs IDLE -> CALC -> COMMIT, so MOVED appears
// two cycles after acceptance and a new step can be taken every third cycle.
module snake_head_stepper #(
  parameter int GRID_W  = 20,
  parameter int GRID_H  = 15,
  parameter int START_X = 10,
  parameter int START_Y = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic       ready,
  input  logic       dir_valid,
  input  logic [1:0] dir_req,
  output logic [1:0] dir,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic       moved,
  output logic       wrapped
);

  localparam logic [4:0] X_MAX   = 5'(GRID_W - 1);
  localparam logic [4:0] Y_MAX   = 5'(GRID_H - 1);
  localparam logic [4:0] X_RESET = 5'(START_X);
  localparam logic [4:0] Y_RESET = 5'(START_Y);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] pend_dir;   // latest accepted heading request
  logic [1:0] step_dir;   // heading frozen for the step in flight
  logic [1:0] dir_eff;    // heading a step accepted this cycle would use
  logic       req_ok;     // dir_req is valid and not a 180-degree reversal
  logic       accept;
  logic [4:0] cand_x, cand_y;
  logic       cand_wrap;

  // Reversal is judged against the committed heading, not the pending one,
  // so the head can never turn back into its own neck.
  assign req_ok  = dir_valid && (dir_req != (dir ^ 2'b10));
  assign accept  = (state == IDLE) && step;
  assign dir_eff = req_ok ? dir_req : pend_dir;
  assign ready   = (state == IDLE);

  // Next-state logic: a step always takes exactly three cycles.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (step) state_nxt = CALC;
      CALC:    state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Candidate head position for the frozen heading, including edge wrap.
  always_comb begin
    cand_x    = x;
    cand_y    = y;
    cand_wrap = 1'b0;
    unique case (step_dir)
      DIR_UP: begin
        if (y == 5'd0) begin
          cand_y    = Y_MAX;
          cand_wrap = 1'b1;
        end else begin
          cand_y = y - 5'd1;
        end
      end
      DIR_RIGHT: begin
        if (x == X_MAX) begin
          cand_x    = 5'd0;
          cand_wrap = 1'b1;
        end else begin
          cand_x = x + 5'd1;
        end
      end
      DIR_DOWN: begin
        if (y == Y_MAX) begin
          cand_y    = 5'd0;
          cand_wrap = 1'b1;
        end else begin
          cand_y = y + 5'd1;
        end
      end
      DIR_LEFT: begin
        if (x == 5'd0) begin
          cand_x    = X_MAX;
          cand_wrap = 1'b1;
        end else begin
          cand_x = x - 5'd1;
        end
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pending heading: any non-reversal request is captured, in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pend_dir <= DIR_RIGHT;
    else if (req_ok) pend_dir <= dir_req;
  end

  // Freeze the heading at acceptance so later requests affect the next step only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      step_dir <= DIR_RIGHT;
    else if (accept) step_dir <= dir_eff;
  end

  // Commit the candidate on leaving CALC; MOVED/WRAPPED are high only in COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= X_RESET;
      y       <= Y_RESET;
      dir     <= DIR_RIGHT;
      moved   <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      moved   <= (state == CALC);
      wrapped <= (state == CALC) && cand_wrap;
      if (state == CALC) begin
        x   <= cand_x;
        y   <= cand_y;
        dir <= step_dir;
      end
    end
  end

endmodule
